btb_fetch_pc_gen: RTL and testbench

- Fetch-stage PC generator with a 1-bit branch history table and branch target buffer (BHT/BTB).
- Holds the fetch PC register; its pc_f output drives the instruction RAM read port A (addra = pc_f[31:2]). Each cycle it selects the next PC: sequential, BTB-predicted, or EX-stage redirect.
- Receives resolved-branch feedback from EX and updates the table. Detects mispredictions, raises flush, and keeps hit/mispredict statistics.

---
 rtl/btb_fetch_pc_gen.sv | 99 +++++++++
 tb/tb_btb_fetch_pc_gen.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/btb_fetch_pc_gen.sv
// Fetch-stage PC generator with a direct-mapped 1-bit-history BTB, EX-stage
// misprediction redirect and branch / misprediction statistics counters.
module btb_fetch_pc_gen #(
  parameter int          ENTRY_BITS = 6,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_f,
  output logic [31:0] pc_f,
  output logic        pred_taken_f,
  output logic [31:0] pred_target_f,
  input  logic        ex_br,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        flush,
  output logic [31:0] br_cnt,
  output logic [31:0] mispred_cnt
);

  localparam int ENTRIES = 1 << ENTRY_BITS;
  localparam int TAG_W   = 32 - ENTRY_BITS - 2;

  logic             valid_q  [ENTRIES];
  logic             hist_q   [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [29:0]      target_q [ENTRIES];

  logic [ENTRY_BITS-1:0] f_idx, ex_idx;
  logic [TAG_W-1:0]      f_tag, ex_tag;
  logic                  f_hit, ex_hit;
  logic [31:0]           pc_f_plus4, ex_pc_plus4;
  logic [31:0]           actual_next, predicted_next, pc_d;

  // Asynchronous lookup keeps the table in registers / distributed RAM.
  always_comb begin
    f_idx         = pc_f[ENTRY_BITS+1:2];
    f_tag         = pc_f[31:ENTRY_BITS+2];
    f_hit         = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    pc_f_plus4    = pc_f + 32'd4;
    pred_taken_f  = f_hit && hist_q[f_idx];
    pred_target_f = pred_taken_f ? {target_q[f_idx], 2'b00} : pc_f_plus4;
  end

  // Masking rather than slicing keeps every target bit in use.
  always_comb begin
    ex_idx         = ex_pc[ENTRY_BITS+1:2];
    ex_tag         = ex_pc[31:ENTRY_BITS+2];
    ex_hit         = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    ex_pc_plus4    = ex_pc + 32'd4;
    actual_next    = ex_taken ? (ex_target & ~32'h3) : ex_pc_plus4;
    predicted_next = ex_pred_taken ? ex_pred_target : ex_pc_plus4;
    flush          = ex_br && (actual_next != predicted_next);
  end

  always_comb begin
    if (flush)             pc_d = actual_next;
    else if (stall_f)      pc_d = pc_f;
    else if (pred_taken_f) pc_d = pred_target_f;
    else                   pc_d = pc_f_plus4;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_f        <= RESET_PC & ~32'h3;
      br_cnt      <= '0;
      mispred_cnt <= '0;
    end else begin
      pc_f <= pc_d & ~32'h3;
      if (ex_br) br_cnt      <= br_cnt + 32'd1;
      if (flush) mispred_cnt <= mispred_cnt + 32'd1;
    end
  end

  // Only the valid bits need reset; tag/target/hist are don't-care when invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
    end else if (ex_br && ex_taken) begin
      valid_q[ex_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && ex_br) begin
      if (ex_taken) begin
        tag_q[ex_idx]    <= ex_tag;
        target_q[ex_idx] <= ex_target[31:2];
        hist_q[ex_idx]   <= 1'b1;
      end else if (ex_hit) begin
        hist_q[ex_idx]   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_btb_fetch_pc_gen.sv
// Directed testbench for btb_fetch_pc_gen: fetch sequencing, BTB training,
// misprediction redirect, stall interaction, aliasing and reset behaviour.
module tb_btb_fetch_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_f;
  logic [31:0] pc_f;
  logic        pred_taken_f;
  logic [31:0] pred_target_f;
  logic        ex_br;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        flush;
  logic [31:0] br_cnt;
  logic [31:0] mispred_cnt;

  int checks = 0;
  int errors = 0;

  btb_fetch_pc_gen #(.ENTRY_BITS(6), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .stall_f(stall_f),
    .pc_f(pc_f), .pred_taken_f(pred_taken_f), .pred_target_f(pred_target_f),
    .ex_br(ex_br), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .flush(flush), .br_cnt(br_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic br, input logic [31:0] pc, input logic taken,
                               input logic [31:0] target, input logic ptaken,
                               input logic [31:0] ptarget);
    ex_br          = br;
    ex_pc          = pc;
    ex_taken       = taken;
    ex_target      = target;
    ex_pred_taken  = ptaken;
    ex_pred_target = ptarget;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    stall_f = 1'b0;
    idle();
    tick();
    tick();
    rst = 1'b0;

    checkOutput("reset_pc", pc_f, 32'h0);
    checkOutput("reset_pred", {31'b0, pred_taken_f}, 32'h0);
    checkOutput("reset_ptgt", pred_target_f, 32'h4);
    checkOutput("reset_br", br_cnt, 32'h0);
    checkOutput("reset_misp", mispred_cnt, 32'h0);
    checkOutput("reset_flush", {31'b0, flush}, 32'h0);
    tick(); checkOutput("seq_4", pc_f, 32'h4);
    tick(); checkOutput("seq_8", pc_f, 32'h8);
    tick(); checkOutput("seq_c", pc_f, 32'hC);
    checkOutput("seq_pred", {31'b0, pred_taken_f}, 32'h0);

    // Cold taken branch at 0x14 -> 0x0C
    applyStimulus(1'b1, 32'h14, 1'b1, 32'hC, 1'b0, 32'h18);
    checkOutput("cold_flush", {31'b0, flush}, 32'h1);
    tick(); idle();
    checkOutput("cold_pc", pc_f, 32'hC);
    checkOutput("cold_br", br_cnt, 32'h1);
    checkOutput("cold_misp", mispred_cnt, 32'h1);
    tick(); checkOutput("cold_seq10", pc_f, 32'h10);
    checkOutput("cold_miss10", {31'b0, pred_taken_f}, 32'h0);
    tick(); checkOutput("cold_pc14", pc_f, 32'h14);
    checkOutput("cold_hit_pred", {31'b0, pred_taken_f}, 32'h1);
    checkOutput("cold_hit_tgt", pred_target_f, 32'hC);
    tick(); checkOutput("cold_follow", pc_f, 32'hC);

    // Loop exit: predicted taken, actually falls through
    applyStimulus(1'b1, 32'h14, 1'b0, 32'hC, 1'b1, 32'hC);
    checkOutput("exit_flush", {31'b0, flush}, 32'h1);
    tick(); idle();
    checkOutput("exit_pc", pc_f, 32'h18);
    checkOutput("exit_br", br_cnt, 32'h2);
    checkOutput("exit_misp", mispred_cnt, 32'h2);
    // Non-branch-table redirect back to 0x14 (0x10 misses, table untouched)
    applyStimulus(1'b1, 32'h10, 1'b0, 32'h0, 1'b1, 32'h80);
    checkOutput("redir_flush", {31'b0, flush}, 32'h1);
    tick(); idle();
    checkOutput("redir_pc", pc_f, 32'h14);
    checkOutput("exit_hist_pred", {31'b0, pred_taken_f}, 32'h0);
    checkOutput("exit_hist_tgt", pred_target_f, 32'h18);

    // Redirect overrides stall, then stall alone holds
    stall_f = 1'b1;
    applyStimulus(1'b1, 32'h3C, 1'b0, 32'h0, 1'b1, 32'h0);
    checkOutput("stflush_flush", {31'b0, flush}, 32'h1);
    tick(); idle();
    checkOutput("stflush_pc", pc_f, 32'h40);
    tick();
    checkOutput("stall_hold", pc_f, 32'h40);
    stall_f = 1'b0;
    checkOutput("stall_br", br_cnt, 32'h4);
    checkOutput("stall_misp", mispred_cnt, 32'h4);

    // Retrain 0x14 taken (predicted correctly), then alias with 0x114
    applyStimulus(1'b1, 32'h14, 1'b1, 32'hC, 1'b1, 32'hC);
    checkOutput("train_flush", {31'b0, flush}, 32'h0);
    tick(); idle();
    checkOutput("train_pc", pc_f, 32'h44);
    checkOutput("train_br", br_cnt, 32'h5);
    checkOutput("train_misp", mispred_cnt, 32'h4);
    applyStimulus(1'b1, 32'h110, 1'b0, 32'h0, 1'b1, 32'h0);
    tick(); idle();
    checkOutput("alias_pc", pc_f, 32'h114);
    checkOutput("alias_pred", {31'b0, pred_taken_f}, 32'h0);
    checkOutput("alias_tgt", pred_target_f, 32'h118);
    applyStimulus(1'b1, 32'h114, 1'b1, 32'h200, 1'b0, 32'h118);
    checkOutput("alias_flush", {31'b0, flush}, 32'h1);
    tick(); idle();
    checkOutput("alias_redir", pc_f, 32'h200);
    applyStimulus(1'b1, 32'h10, 1'b0, 32'h0, 1'b1, 32'h80);
    tick(); idle();
    checkOutput("alias_back", pc_f, 32'h14);
    checkOutput("alias_evict", {31'b0, pred_taken_f}, 32'h0);
    checkOutput("alias_br", br_cnt, 32'h8);
    checkOutput("alias_misp", mispred_cnt, 32'h7);

    // Correct prediction with target low bits set; same-cycle lookup sees old entry
    stall_f = 1'b1;
    applyStimulus(1'b1, 32'h14, 1'b1, 32'hE, 1'b1, 32'hC);
    checkOutput("lowbits_flush", {31'b0, flush}, 32'h0);
    checkOutput("sameidx_old", {31'b0, pred_taken_f}, 32'h0);
    tick(); idle();
    stall_f = 1'b0;
    checkOutput("lowbits_hold", pc_f, 32'h14);
    checkOutput("sameidx_new", {31'b0, pred_taken_f}, 32'h1);
    checkOutput("lowbits_tgt", pred_target_f, 32'hC);
    checkOutput("lowbits_br", br_cnt, 32'h9);
    checkOutput("lowbits_misp", mispred_cnt, 32'h7);

    // Reset in the same cycle as a mispredicted update
    rst = 1'b1;
    applyStimulus(1'b1, 32'h14, 1'b1, 32'hC, 1'b0, 32'h18);
    checkOutput("rstupd_flush", {31'b0, flush}, 32'h1);
    tick(); idle();
    rst = 1'b0;
    checkOutput("rstupd_pc", pc_f, 32'h0);
    checkOutput("rstupd_br", br_cnt, 32'h0);
    checkOutput("rstupd_misp", mispred_cnt, 32'h0);
    checkOutput("rstupd_ptgt", pred_target_f, 32'h4);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("rstupd_pc14", pc_f, 32'h14);
    checkOutput("rstupd_cleared", {31'b0, pred_taken_f}, 32'h0);
    checkOutput("rstupd_clr_tgt", pred_target_f, 32'h18);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
